// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if
// Bundles the CPU load/store port and the 256-bit line-memory handshake of
// the L1 data cache controller. Signal suffixes are written from the
// controller's point of view (_i = into the controller, _o = out of it).
//
//   cpu_addr_i   [31:0]   byte address (word select = [4:2])
//   cpu_data_i   [31:0]   store data
//   cpu_read_i            load request, level
//   cpu_write_i           store request, level, wins over cpu_read_i
//   cpu_data_o   [31:0]   load data
//   cpu_stall_o           request not complete this cycle
//   mem_addr_o   [31:0]   line address, [4:0] = 0
//   mem_data_o   [255:0]  victim line for write-back
//   mem_enable_o          memory request
//   mem_write_o           1 = write-back, 0 = refill
//   mem_data_i   [255:0]  refill line, valid while mem_ack_i is high
//   mem_ack_i             one-cycle completion pulse
//
// Modports: master = cache controller, slave = CPU + memory environment.
// ---------------------------------------------------------------------------
interface dcache_ctrl_if;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache controller between
// a CPU load/store port and a 256-bit line memory. Hits complete with no
// stall; a miss stalls the CPU while the dirty victim (if any) is written
// back and the line is refilled.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   bus          dcache_ctrl_if.master (CPU port + line-memory handshake)
//   hit_cnt_o    [31:0] completed requests that did not miss  (stats build)
//   miss_cnt_o   [31:0] misses taken                           (stats build)
//
// Build option: define DCACHE_STATS_EN to add the hit/miss counters and
// their output ports. Without it the ports and counters do not exist.
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int LINES = 32,
    parameter int IDX_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dcache_ctrl_if.master  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]    hit_cnt_o,
    output logic [31:0]    miss_cnt_o
`endif
);

    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2,
        FILL  = 2'd3
    } state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];

    // Index/tag of the miss being serviced; the CPU request is not trusted
    // to stay stable while stalled.
    logic [IDX_W-1:0]   miss_idx_q;
    logic [TAG_W-1:0]   miss_tag_q;

    logic               mem_enable_q;
    logic               mem_write_q;
    logic [31:0]        mem_addr_q;
    logic [255:0]       mem_data_q;

    // Request decode
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic               req;
    logic               hit;
    logic               idle_hit;
    logic               wr_hit;
    logic               rd_done;
    logic               fill_we;
    logic [255:0]       cur_line;
    logic               unused_addr_bits;

    assign idx  = bus.cpu_addr_i[5+IDX_W-1:5];
    assign tag  = bus.cpu_addr_i[31:5+IDX_W];
    assign word = bus.cpu_addr_i[4:2];
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign req      = bus.cpu_read_i | bus.cpu_write_i;
    assign hit      = req & valid_q[idx] & (tag_q[idx] == tag);
    assign idle_hit = (state_q == IDLE) & hit;
    assign wr_hit   = idle_hit & bus.cpu_write_i;
    assign rd_done  = idle_hit & bus.cpu_read_i & ~bus.cpu_write_i;

    // Refill lands only when the ALLOC request is actually outstanding.
    assign fill_we  = (state_q == ALLOC) & mem_enable_q & bus.mem_ack_i;

    assign cur_line = data_q[idx];

    // Load data is forced to zero unless a read hit completes, so the port
    // never exposes the unreset data array.
    assign bus.cpu_data_o  = rd_done ? cur_line[{word, 5'b0} +: 32] : 32'h0;
    assign bus.cpu_stall_o = req & ~idle_hit;

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

    // -----------------------------------------------------------------------
    // Controller FSM with registered memory-side outputs and valid/dirty state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        miss_idx_q   <= idx;
                        miss_tag_q   <= tag;
                        mem_enable_q <= 1'b1;
                        if (dirty_q[idx]) begin
                            state_q     <= WB;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx, 5'b0};
                            mem_data_q  <= data_q[idx];
                        end else begin
                            state_q     <= ALLOC;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {tag, idx, 5'b0};
                        end
                    end else if (wr_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end

                WB: begin
                    // Drop the request on ack; ALLOC re-raises it one cycle
                    // later, giving the mandatory idle cycle between requests.
                    if (bus.mem_ack_i) begin
                        mem_enable_q <= 1'b0;
                        state_q      <= ALLOC;
                    end
                end

                ALLOC: begin
                    if (!mem_enable_q) begin
                        mem_enable_q <= 1'b1;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= {miss_tag_q, miss_idx_q, 5'b0};
                    end else if (bus.mem_ack_i) begin
                        mem_enable_q        <= 1'b0;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        state_q             <= FILL;
                    end
                end

                FILL: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Tag and data arrays (not reset; valid_q qualifies every use)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= bus.mem_data_i;
        end else if (wr_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= bus.cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    // -----------------------------------------------------------------------
    // Hit/miss statistics. missed_q marks that the request now completing is
    // the one that just missed, so its post-fill completion is not a hit.
    // -----------------------------------------------------------------------
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        missed_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
                missed_q   <= 1'b1;
            end else if (idle_hit) begin
                if (!missed_q) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
                missed_q <= 1'b0;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
